// File: rtl/area_ret_seq.sv
// area_ret_seq: sequential right-triangle checker with one shared shift-add multiplier.
// Define TRI_CLASS_EN to add the cls (none/acute/right/obtuse) output.
module area_ret_seq #(
   parameter int N = 16
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic [N-1:0]   c,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           ret,
   output logic [2*N-2:0] area
`ifdef TRI_CLASS_EN
   ,
   output logic [1:0]     cls
`endif
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   typedef enum logic [2:0] {IDLE, SORT, MUL, CHECK, DONE} state_t;
   state_t state, state_nx;
   logic [N-1:0] ra, rb, rc, hyp, l1, l2, mcand, hyp_c, l1_c, l2_c;
   logic [2*N-1:0] acc, acc_nx, hh;
   logic [2*N:0] sq;
   logic [N:0] part;
   logic [CW-1:0] cnt;
   logic [1:0] sel;
   logic a_top, b_top, mul_last, nz;
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      mul_last = state == MUL && sel == 2'd3 && cnt == LAST;
      state_nx = state == IDLE ? (in_valid ? SORT : IDLE) :
                 state == SORT ? MUL :
                 state == MUL ? (mul_last ? CHECK : MUL) :
                 state == CHECK ? DONE :
                 out_ready ? IDLE : DONE;
   end
   always_comb begin
      in_ready = state == IDLE;
      out_valid = state == DONE;
   end
   // ties go to the earliest side; the legs keep their original a, b, c order
   always_comb begin
      a_top = ra >= rb && ra >= rc;
      b_top = !a_top && rb >= rc;
      hyp_c = a_top ? ra : b_top ? rb : rc;
      l1_c = a_top ? rb : ra;
      l2_c = (a_top || b_top) ? rc : rb;
   end
   // low half of acc holds the remaining multiplier bits, high half the partial product
   always_comb begin
      part = {1'b0, acc[2*N-1:N]} + {1'b0, acc[0] ? mcand : {N{1'b0}}};
      acc_nx = {part, acc[N-1:1]};
      nz = |hyp && |l1 && |l2;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         ret <= 1'b0;
         area <= '0;
`ifdef TRI_CLASS_EN
         cls <= 2'b00;
`endif
      end else begin
         if (state == IDLE && in_valid) begin
            ra <= a;
            rb <= b;
            rc <= c;
         end
         if (state == SORT) begin
            hyp <= hyp_c;
            l1 <= l1_c;
            l2 <= l2_c;
            mcand <= hyp_c;
            acc <= {{N{1'b0}}, hyp_c};
            cnt <= '0;
            sel <= 2'd0;
         end
         if (state == MUL) begin
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
            if (cnt != LAST || sel == 2'd3) acc <= acc_nx;
            else begin
               acc <= {{N{1'b0}}, sel == 2'd0 ? l1 : l2};
               mcand <= sel == 2'd1 ? l2 : l1;
            end
            if (cnt == LAST) begin
               sel <= sel + 1'b1;
               if (sel == 2'd0) hh <= acc_nx;
               if (sel == 2'd1) sq <= {1'b0, acc_nx};
               if (sel == 2'd2) sq <= sq + {1'b0, acc_nx};
            end
         end
         if (state == CHECK) begin
            ret <= {1'b0, hh} == sq && nz;
            area <= acc[2*N-1:1];
`ifdef TRI_CLASS_EN
            cls <= !(nz && {1'b0, hyp} < {1'b0, l1} + {1'b0, l2}) ? 2'b00 :
                   {1'b0, hh} == sq ? 2'b10 :
                   {1'b0, hh} < sq ? 2'b01 : 2'b11;
`endif
         end
      end
   end
endmodule

// File: doc/area_ret_seq.md
Name: area_ret_seq

Overview:
- Sequential, parametrised successor to the combinational right-triangle checker.
- Accepts three N-bit natural sides through a valid/ready handshake and finds the hypotenuse candidate.
- Computes the squares and the leg product with a single shared iterative shift-add multiplier, then returns ret and area through a valid/ready output handshake.
- Sits between a side-producing datapath and a result consumer. One triangle in flight; area and power are traded for latency.

Parameters:
N, 16, width in bits of each side a, b, c (N >= 2)

Ports:
clock  input  1  single system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  a, b, c valid this cycle
in_ready  output  1  block can accept a triangle (high only in IDLE)
a  input  N  side A, natural
b  input  N  side B, natural
c  input  N  side C, natural
out_valid  output  1  ret/area valid, held until accepted
out_ready  input  1  consumer accepts result
ret  output  1  1 if sides form a right triangle with all sides nonzero
area  output  2N-1  floor(leg1*leg2/2), significant only when ret=1

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled on the clock edge and overrides everything.
- Reset values: state=IDLE, out_valid=0, ret=0, area=0, in_ready=1 in the cycle after reset.
- FSM states: IDLE, SORT, MUL, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, register a, b, c and go to SORT.
- SORT (1 cycle):
  - hyp = max(a,b,c). Ties resolve in priority a > b > c.
  - leg1, leg2 = the remaining two sides, in original a, b, c order.
  - Then go to MUL.
- MUL:
  - Shared N-cycle shift-add multiplier, 1 multiplier bit per cycle, N x N -> 2N-bit product.
  - Four products, in this order: hyp*hyp, leg1*leg1, leg2*leg2, leg1*leg2. Total 4N cycles. Then go to CHECK.
- CHECK (1 cycle):
  - sum = leg1^2 + leg2^2, computed on 2N+1 bits, so there is no overflow.
  - ret = (hyp^2 == sum) & (a != 0) & (b != 0) & (c != 0).
  - area = (leg1*leg2) >> 1, truncated to 2N-1 bits, which is lossless.
  - Go to DONE.
- DONE:
  - out_valid=1. ret and area are held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly 4N+2 edges after the accepting edge.
  - Minimum issue interval: 4N+4 cycles (back-to-back with out_ready tied high).
- No input overlap: in_ready=0 in every state except IDLE. in_valid is ignored outside IDLE. The input registers must not change outside IDLE.
- out_ready asserted while out_valid=0 has no effect.
- Output registers ret and area update only in CHECK. Between results they keep their last values.
- Reset mid-operation (any state): the in-flight triangle is discarded and no out_valid is produced for it. The next edge is IDLE, with the reset values applied.
- Degenerate input: (0,0,0) and any side equal to 0 give ret=0, even though 0 = 0 + 0 is arithmetically true.

Optional Feature:
- Macro TRI_CLASS_EN.
- When defined, add output cls (2 bits), valid with out_valid, registered in CHECK, reset value 2'b00:
  - 00 = not a triangle (hyp >= leg1+leg2, computed on N+1 bits, or any side 0)
  - 01 = acute (hyp^2 < sum)
  - 10 = right (equals ret)
  - 11 = obtuse (hyp^2 > sum)
- Classification reuses the existing products; it adds no cycles and the latency is unchanged.
- When not defined, the cls port and its logic are absent. ports and timing are otherwise identical.

Test Plan:
- Reset, then send (3,4,5) with out_ready=1 -> in_ready drops next cycle; out_valid after exactly 66 edges (N=16); ret=1, area=6; with TRI_CLASS_EN, cls=10.
- Send (13,5,12), then (1,1,1) -> first result ret=1, area=30 (hyp=13 taken from a). Second result ret=0 (TRI_CLASS_EN: cls=01).
- Send (39321,52428,65535) -> ret=1, area=1030760694; checks full-width sum without overflow.
- Send (0,0,0), then (2,3,7) -> ret=0 for both. TRI_CLASS_EN: cls=00 for both. For (2,3,4), cls=11.
- Hold out_ready=0 for 10 cycles after out_valid, pulsing in_valid with (6,8,10) -> out_valid, ret and area stay stable; in_ready stays 0; the pulsed triangle is not captured. On release, in_ready returns the next cycle.
- Assert reset for 1 cycle mid-MUL on (3,4,5) -> next cycle in_ready=1, out_valid=0; no stale result ever appears; a new (5,12,13) then gives ret=1, area=30.
